mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter.sv | 121 ++++++++++++
 tb/tb_mem_arbiter.sv | 485 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - fetch, data and unified memory buses of mem_arbiter
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;

    logic        dm_req;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_ready;
    logic [31:0] dm_rdata;

    logic        mem_req;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    // slave: the arbiter itself
    modport slave (
        input  if_req, if_addr, dm_req, dm_be, dm_addr, dm_wdata, mem_ack, mem_rdata,
        output if_ready, if_rdata, dm_ready, dm_rdata, mem_req, mem_be, mem_addr, mem_wdata
    );

    // master: the pipeline stages and the memory around the arbiter
    modport master (
        output if_req, if_addr, dm_req, dm_be, dm_addr, dm_wdata, mem_ack, mem_rdata,
        input  if_ready, if_rdata, dm_ready, dm_rdata, mem_req, mem_be, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - fetch/data arbiter onto one memory port; MEM_ARB_TIMEOUT_EN enables the ack timeout
module mem_arbiter #(
    parameter int FAIR_LIMIT     = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus,
    output logic         err
);
    localparam int FAIR_W = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);
    localparam logic [FAIR_W-1:0] FAIR_MAX = FAIR_W'(FAIR_LIMIT);

    typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, RESP} state_t;

    state_t            state, state_next;
    logic [FAIR_W-1:0] fair_cnt;
    logic              resp_dm;
    logic              grant_if, grant_dm;
    logic              in_acc;
    logic              timeout_hit;

    assign in_acc       = (state == IF_ACC) || (state == DM_ACC);
    assign bus.mem_req  = in_acc;
    assign bus.if_ready = (state == RESP) && !resp_dm;
    assign bus.dm_ready = (state == RESP) && resp_dm;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    // Fires on the last waiting cycle; an ack in that same cycle still wins.
    assign timeout_hit = in_acc && !bus.mem_ack && (to_cnt == TO_LAST);
    assign err         = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            to_cnt <= (in_acc && !bus.mem_ack && !timeout_hit) ? to_cnt + 1'b1 : '0;
            if (timeout_hit)
                err_q <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign err         = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        case (state)
            IDLE: begin
                // Data normally wins; a starved fetch takes over once the limit is hit.
                if (bus.if_req && (!bus.dm_req || fair_cnt >= FAIR_MAX)) begin
                    grant_if   = 1'b1;
                    state_next = IF_ACC;
                end else if (bus.dm_req) begin
                    grant_dm   = 1'b1;
                    state_next = DM_ACC;
                end
            end
            IF_ACC, DM_ACC: begin
                if (bus.mem_ack || timeout_hit)
                    state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.mem_addr  <= '0;
            bus.mem_be    <= '0;
            bus.mem_wdata <= '0;
            bus.if_rdata  <= '0;
            bus.dm_rdata  <= '0;
            resp_dm       <= 1'b0;
            fair_cnt      <= '0;
        end else begin
            if (grant_if) begin
                bus.mem_addr  <= bus.if_addr;
                bus.mem_be    <= 4'b0000;
                bus.mem_wdata <= '0;
                resp_dm       <= 1'b0;
                fair_cnt      <= '0;
            end else if (grant_dm) begin
                bus.mem_addr  <= bus.dm_addr;
                bus.mem_be    <= bus.dm_be;
                bus.mem_wdata <= bus.dm_wdata;
                resp_dm       <= 1'b1;
                fair_cnt      <= bus.if_req ? fair_cnt + 1'b1 : '0;
            end else if (state == IDLE && !bus.if_req) begin
                fair_cnt <= '0;
            end

            if (state == IF_ACC && (bus.mem_ack || timeout_hit))
                bus.if_rdata <= bus.mem_ack ? bus.mem_rdata : '0;

            // Stores keep the previous load result; a timed-out access reads as zero.
            if (state == DM_ACC && bus.mem_ack && bus.mem_be == 4'b0000)
                bus.dm_rdata <= bus.mem_rdata;
            else if (state == DM_ACC && timeout_hit)
                bus.dm_rdata <= '0;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized bench for mem_arbiter with a transaction-level memory model
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst;
    logic err;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus),
        .err (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } acc_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mem_model [logic [31:0]];
    acc_t        log_q [$];
    bit          rsp_en      = 1'b1;
    bit          rand_delay  = 1'b0;
    int          fixed_delay = 0;
    logic [31:0] exp_if = '0;
    logic [31:0] exp_dm = '0;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (mem_model.exists(a))
            return mem_model[a];
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic void mem_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] v;
        v = mem_read(a);
        for (int b = 0; b < 4; b++)
            if (be[b]) v[b*8 +: 8] = d[b*8 +: 8];
        mem_model[a] = v;
    endfunction

    // Memory responder: acks after a chosen number of waiting cycles and logs each completed access.
    initial begin : responder
        bit busy;
        int wait_cnt;
        int cur_delay;
        acc_t e;
        busy = 0;
        wait_cnt = 0;
        cur_delay = 0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            if (!rsp_en || rst || !bus.mem_req) begin
                busy = 0;
            end else begin
                if (!busy) begin
                    busy = 1;
                    wait_cnt = 0;
                    cur_delay = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
                end
                if (wait_cnt == cur_delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem_read(bus.mem_addr);
                    e.addr = bus.mem_addr;
                    e.be = bus.mem_be;
                    e.wdata = bus.mem_wdata;
                    log_q.push_back(e);
                    if (bus.mem_be != 4'b0000)
                        mem_write(bus.mem_addr, bus.mem_be, bus.mem_wdata);
                    busy = 0;
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Caller is at a negedge; returns at the negedge where if_ready was seen (lat = -1 on timeout).
    task automatic cpu_fetch(input logic [31:0] a, output logic [31:0] d, output int lat);
        bus.if_req  = 1'b1;
        bus.if_addr = a;
        lat = -1;
        d = '0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (bus.if_ready) begin
                lat = i;
                d = bus.if_rdata;
                break;
            end
        end
        bus.if_req = 1'b0;
    endtask

    task automatic cpu_data(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                            input bit keep, output logic [31:0] d, output int lat);
        bus.dm_req   = 1'b1;
        bus.dm_addr  = a;
        bus.dm_be    = be;
        bus.dm_wdata = wd;
        lat = -1;
        d = '0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (bus.dm_ready) begin
                lat = i;
                d = bus.dm_rdata;
                break;
            end
        end
        if (!keep || lat < 0) bus.dm_req = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        bus.if_req = 1'b0;
        bus.dm_req = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_if = '0;
        exp_dm = '0;
    endtask

    task automatic test_reset();
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_req = 1'b0; bus.dm_be = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
        rst = 1'b1;
        #1;
        n_tests++;
        if ({bus.mem_req, bus.if_ready, bus.dm_ready, err, bus.mem_be} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 00000000", {bus.mem_req, bus.if_ready, bus.dm_ready, err, bus.mem_be});
        end
        n_tests++;
        if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_mem_fields: got %h required 0", {bus.mem_addr, bus.mem_wdata});
        end
        n_tests++;
        if ({bus.if_rdata, bus.dm_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h required 0", {bus.if_rdata, bus.dm_rdata});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: mem_req got %b required 0", bus.mem_req);
        end
    endtask

    task automatic test_fetch_basic();
        rand_delay = 0;
        fixed_delay = 0;
        mem_model[32'h100] = 32'h0000_0013;
        @(negedge clk);
        bus.if_req = 1'b1;
        bus.if_addr = 32'h100;
        @(negedge clk);
        n_tests++;
        if ({bus.mem_req, bus.if_ready, bus.mem_be} !== 6'b100000 || bus.mem_addr !== 32'h100) begin
            n_fail++;
            $display("FAIL fetch_mem_req: got req=%b rdy=%b be=%b addr=%h required 1 0 0000 00000100",
                     bus.mem_req, bus.if_ready, bus.mem_be, bus.mem_addr);
        end
        @(negedge clk);
        n_tests++;
        if (bus.if_ready !== 1'b1 || bus.if_rdata !== 32'h13 || bus.mem_req !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_ready: got rdy=%b rdata=%h req=%b required 1 00000013 0",
                     bus.if_ready, bus.if_rdata, bus.mem_req);
        end
        bus.if_req = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.if_ready !== 1'b0 || bus.if_rdata !== 32'h13) begin
            n_fail++;
            $display("FAIL fetch_pulse: got rdy=%b rdata=%h required 0 00000013", bus.if_ready, bus.if_rdata);
        end
        exp_if = 32'h13;
    endtask

    task automatic test_simultaneous();
        logic [31:0] fd, dd;
        int fl, dl;
        int base;
        rand_delay = 0;
        fixed_delay = 1;
        mem_model[32'h2000] = $urandom;
        base = log_q.size();
        @(negedge clk);
        fork
            cpu_fetch(32'h104, fd, fl);
            cpu_data(32'h2000, 4'b0000, 32'h0, 1'b0, dd, dl);
        join
        n_tests++;
        if (!(dl > 0 && fl > dl)) begin
            n_fail++;
            $display("FAIL simul_order: got dm_lat=%0d if_lat=%0d required 0 < dm_lat < if_lat", dl, fl);
        end
        n_tests++;
        if (log_q.size() != base + 2 || log_q[base].addr !== 32'h2000 || log_q[base+1].addr !== 32'h104) begin
            n_fail++;
            $display("FAIL simul_grants: got %0d accesses required data@2000 then fetch@104", log_q.size() - base);
        end
        n_tests++;
        if (dd !== mem_read(32'h2000) || fd !== mem_read(32'h104)) begin
            n_fail++;
            $display("FAIL simul_data: got dm=%h if=%h required dm=%h if=%h", dd, fd,
                     mem_read(32'h2000), mem_read(32'h104));
        end
        exp_dm = mem_read(32'h2000);
        exp_if = mem_read(32'h104);
    endtask

    task automatic test_fairness();
        logic [31:0] fd, d1, d2, d3;
        int fl, l1, l2, l3;
        int base;
        logic [31:0] want [4];
        want = '{32'h2010, 32'h2014, 32'h180, 32'h2018};
        rand_delay = 1;
        base = log_q.size();
        @(negedge clk);
        fork
            cpu_fetch(32'h180, fd, fl);
            begin
                cpu_data(32'h2010, 4'b0000, 32'h0, 1'b1, d1, l1);
                cpu_data(32'h2014, 4'b0000, 32'h0, 1'b1, d2, l2);
                cpu_data(32'h2018, 4'b0000, 32'h0, 1'b0, d3, l3);
            end
        join
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (log_q.size() <= base + i) begin
                n_fail++;
                $display("FAIL fair_grant%0d: got no access required addr %h", i, want[i]);
            end else if (log_q[base+i].addr !== want[i]) begin
                n_fail++;
                $display("FAIL fair_grant%0d: got addr %h required %h", i, log_q[base+i].addr, want[i]);
            end
        end
        n_tests++;
        if (fd !== mem_read(32'h180) || d3 !== mem_read(32'h2018)) begin
            n_fail++;
            $display("FAIL fair_data: got if=%h dm=%h required if=%h dm=%h", fd, d3,
                     mem_read(32'h180), mem_read(32'h2018));
        end
        exp_if = mem_read(32'h180);
        exp_dm = mem_read(32'h2018);
    endtask

    task automatic test_store();
        logic [31:0] dd;
        int dl;
        int req_cycles, bad;
        rand_delay = 0;
        fixed_delay = 3;
        req_cycles = 0;
        bad = 0;
        @(negedge clk);
        fork
            cpu_data(32'h3000, 4'b0011, 32'hDEAD_BEEF, 1'b0, dd, dl);
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (bus.mem_req) begin
                    req_cycles++;
                    if (bus.mem_be !== 4'b0011 || bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_addr !== 32'h3000)
                        bad++;
                end
                if (bus.dm_ready) break;
            end
        join
        n_tests++;
        if (bad != 0 || req_cycles != 4) begin
            n_fail++;
            $display("FAIL store_fields: got %0d unstable of %0d req cycles required 0 of 4", bad, req_cycles);
        end
        n_tests++;
        if (dl < 0 || dd !== exp_dm) begin
            n_fail++;
            $display("FAIL store_dm_rdata: got %h (lat %0d) required unchanged %h", dd, dl, exp_dm);
        end
    endtask

    task automatic test_random();
        logic [31:0] fa, da, wd, fd, dd, exp_load;
        logic [3:0]  be;
        int kind, fl, dl, base, n_exp;
        acc_t want [2];
        rand_delay = 1;
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 2));
            fa = 32'h100 + 32'($urandom_range(0, 7)) * 4;
            da = 32'h4000 + 32'($urandom_range(0, 3)) * 4;
            be = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'b0000;
            wd = $urandom;
            exp_load = mem_read(da);
            base = log_q.size();
            fl = 0;
            dl = 0;
            fd = '0;
            dd = '0;
            @(negedge clk);
            case (kind)
                0: cpu_fetch(fa, fd, fl);
                1: cpu_data(da, be, wd, 1'b0, dd, dl);
                default: fork
                    cpu_fetch(fa, fd, fl);
                    cpu_data(da, be, wd, 1'b0, dd, dl);
                join
            endcase
            n_exp = 0;
            if (kind != 0) begin
                want[n_exp] = '{addr: da, be: be, wdata: wd};
                n_exp++;
            end
            if (kind != 1) begin
                want[n_exp] = '{addr: fa, be: 4'b0000, wdata: 32'h0};
                n_exp++;
            end
            n_tests++;
            if (fl < 0 || dl < 0) begin
                n_fail++;
                $display("FAIL rand%0d_timeout: got if_lat=%0d dm_lat=%0d required completion", it, fl, dl);
            end
            n_tests++;
            if (log_q.size() != base + n_exp) begin
                n_fail++;
                $display("FAIL rand%0d_count: got %0d accesses required %0d", it, log_q.size() - base, n_exp);
            end else begin
                for (int j = 0; j < n_exp; j++)
                    if (log_q[base+j] != want[j]) begin
                        n_fail++;
                        $display("FAIL rand%0d_access%0d: got %h/%b/%h required %h/%b/%h", it, j,
                                 log_q[base+j].addr, log_q[base+j].be, log_q[base+j].wdata,
                                 want[j].addr, want[j].be, want[j].wdata);
                    end
            end
            if (kind != 1) begin
                exp_if = mem_read(fa);
                n_tests++;
                if (fd !== exp_if) begin
                    n_fail++;
                    $display("FAIL rand%0d_if_rdata: got %h required %h", it, fd, exp_if);
                end
            end
            if (kind != 0) begin
                if (be == 4'b0000) exp_dm = exp_load;
                n_tests++;
                if (dd !== exp_dm) begin
                    n_fail++;
                    $display("FAIL rand%0d_dm_rdata: got %h required %h", it, dd, exp_dm);
                end
            end
            n_tests++;
            if (bus.if_rdata !== exp_if || bus.dm_rdata !== exp_dm) begin
                n_fail++;
                $display("FAIL rand%0d_hold: got if=%h dm=%h required if=%h dm=%h", it,
                         bus.if_rdata, bus.dm_rdata, exp_if, exp_dm);
            end
        end
    endtask

    task automatic test_reset_mid();
        int seen, stray;
        rsp_en = 0;
        seen = 0;
        stray = 0;
        @(negedge clk);
        bus.dm_req = 1'b1;
        bus.dm_addr = 32'h2000;
        bus.dm_be = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_req) begin
                seen = 1;
                break;
            end
        end
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (seen != 1 || bus.mem_req !== 1'b0 || bus.dm_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_drop: got seen=%0d req=%b rdy=%b required 1 0 0", seen, bus.mem_req, bus.dm_ready);
        end
        bus.dm_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rsp_en = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.mem_req || bus.dm_ready || bus.if_ready) stray++;
        end
        n_tests++;
        if (stray != 0 || bus.dm_rdata !== 32'h0 || bus.if_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL rstmid_idle: got %0d active cycles dm=%h if=%h required 0 0 0",
                     stray, bus.dm_rdata, bus.if_rdata);
        end
        exp_dm = '0;
        exp_if = '0;
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [31:0] dd;
        int dl, req_cycles;
        rsp_en = 0;
        req_cycles = 0;
        @(negedge clk);
        fork
            cpu_data(32'h4000, 4'b0000, 32'h0, 1'b0, dd, dl);
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (bus.mem_req) req_cycles++;
                if (bus.dm_ready) break;
            end
        join
        n_tests++;
        if (req_cycles != 16 || dl < 0 || dd !== 32'h0 || err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_abort: got req_cycles=%0d lat=%0d dm=%h err=%b required 16 >=0 0 1",
                     req_cycles, dl, dd, err);
        end
        repeat (3) @(negedge clk);
        n_tests++;
        if (err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_sticky: err got %b required 1", err);
        end
        rsp_en = 1;
        apply_reset();
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_clear: err got %b required 0", err);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fetch_basic();
        test_simultaneous();
        test_fairness();
        test_store();
        test_random();
        test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`else
        n_tests++;
        if (err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_tied: err got %b required 0", err);
        end
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
